sonuc_yazici: RTL and testbench

SONUC_YAZICI -- requirements
Module: sonuc_yazici

---
 rtl/sonuc_yazici.sv | 110 +++++++++++
 tb/tb_sonuc_yazici.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sonuc_yazici.sv
// sonuc_yazici: buffers filter results in a small FIFO and writes them to frame memory.
// Optional clamp to [0, 2^OUT_BIT-1] at acceptance when SONUC_DOYUM_EN is defined.
`ifndef PIXEL_BIT
`define PIXEL_BIT 12
`endif
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 4
`endif
`ifndef IMG_WIDTH_BIT
`define IMG_WIDTH_BIT 4
`endif
`ifndef IMG_HEIGHT_BIT
`define IMG_HEIGHT_BIT 3
`endif

module sonuc_yazici #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_BIT = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rstn_i,
  input  logic [`PIXEL_BIT-1:0]                     res_veri_i,
  input  logic [`IMG_HEIGHT_BIT-1:0]                res_row_i,
  input  logic [`IMG_WIDTH_BIT-1:0]                 res_col_i,
  input  logic                                      res_gecerli_i,
  output logic                                      res_hazir_o,
  output logic [`IMG_HEIGHT_BIT+`IMG_WIDTH_BIT-1:0] mem_adres_o,
  output logic [OUT_BIT-1:0]                        mem_veri_o,
  output logic                                      mem_gecerli_o,
  input  logic                                      mem_hazir_i,
  output logic                                      yazici_bitti_o
);
  localparam int HB = `IMG_HEIGHT_BIT;
  localparam int WB = `IMG_WIDTH_BIT;
  localparam int AW = HB + WB;
  localparam int PB = `PIXEL_BIT;
  localparam int N = `IMG_WIDTH * `IMG_HEIGHT;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {CALIS, BOSALT, BITTI} state_t;

  state_t state, state_n;
  logic [KW-1:0] kabul_sayac;
  logic [CW-1:0] cnt, cnt_n, wr_idx;
  logic [AW-1:0] q_adres [FIFO_DEPTH];
  logic [OUT_BIT-1:0] q_veri [FIFO_DEPTH];
  logic in_range, push, pop;
  logic [AW-1:0] adres;
  logic [OUT_BIT-1:0] veri;

`ifdef SONUC_DOYUM_EN
  assign veri = res_veri_i[PB-1] ? '0 : (|res_veri_i[PB-2:OUT_BIT]) ? '1 : res_veri_i[OUT_BIT-1:0];
`else
  logic unused_ust;
  assign unused_ust = ^res_veri_i[PB-1:OUT_BIT];
  assign veri = res_veri_i[OUT_BIT-1:0];
`endif

  always_comb begin
    in_range = ({1'b0, res_row_i} < (HB+1)'(`IMG_HEIGHT)) && ({1'b0, res_col_i} < (WB+1)'(`IMG_WIDTH));
    push = res_gecerli_i && res_hazir_o && in_range;
    pop = mem_gecerli_o && mem_hazir_i;
    cnt_n = cnt + CW'(push) - CW'(pop);
    wr_idx = pop ? cnt - CW'(1) : cnt;
    adres = AW'(res_row_i) * AW'(`IMG_WIDTH) + AW'(res_col_i);
    state_n = (state == CALIS && push && kabul_sayac == KW'(N - 1)) ? BOSALT :
              (state == BOSALT && cnt_n == '0) ? BITTI : state;
  end

  // head of the queue always sits in slot 0 so the memory port is driven straight from flops
  assign mem_adres_o = q_adres[0];
  assign mem_veri_o = q_veri[0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= CALIS;
      kabul_sayac <= '0;
      cnt <= '0;
      res_hazir_o <= 1'b0;
      mem_gecerli_o <= 1'b0;
      yazici_bitti_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_adres[i] <= '0;
        q_veri[i] <= '0;
      end
    end else begin
      state <= state_n;
      kabul_sayac <= kabul_sayac + KW'(push);
      cnt <= cnt_n;
      res_hazir_o <= state_n == CALIS && cnt_n != CW'(FIFO_DEPTH);
      mem_gecerli_o <= cnt_n != '0;
      yazici_bitti_o <= state_n == BITTI;
      if (pop)
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          q_adres[i] <= q_adres[i+1];
          q_veri[i] <= q_veri[i+1];
        end
      if (push)
        for (int i = 0; i < FIFO_DEPTH; i++)
          if (CW'(i) == wr_idx) begin
            q_adres[i] <= adres;
            q_veri[i] <= veri;
          end
    end
  end
endmodule

// File: tb/tb_sonuc_yazici.sv
// tb_sonuc_yazici: vector table, backpressure, completion and reset-abort checks for sonuc_yazici.
`ifndef PIXEL_BIT
`define PIXEL_BIT 12
`endif
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef IMG_HEIGHT
`define IMG_HEIGHT 4
`endif
`ifndef IMG_WIDTH_BIT
`define IMG_WIDTH_BIT 4
`endif
`ifndef IMG_HEIGHT_BIT
`define IMG_HEIGHT_BIT 3
`endif

module tb_sonuc_yazici;
  localparam int PB = `PIXEL_BIT;
  localparam int HB = `IMG_HEIGHT_BIT;
  localparam int WB = `IMG_WIDTH_BIT;
  localparam int AW = HB + WB;
  localparam int W = `IMG_WIDTH;
  localparam int H = `IMG_HEIGHT;
  localparam int N = W * H;
  localparam int D = 4;
  localparam int OB = 8;
  localparam int MAXV = (1 << OB) - 1;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic [PB-1:0] res_veri_i = '0;
  logic [HB-1:0] res_row_i = '0;
  logic [WB-1:0] res_col_i = '0;
  logic res_gecerli_i = 1'b0;
  logic res_hazir_o;
  logic [AW-1:0] mem_adres_o;
  logic [OB-1:0] mem_veri_o;
  logic mem_gecerli_o;
  logic mem_hazir_i = 1'b0;
  logic yazici_bitti_o;

  sonuc_yazici #(.FIFO_DEPTH(D), .OUT_BIT(OB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .res_veri_i(res_veri_i), .res_row_i(res_row_i),
    .res_col_i(res_col_i), .res_gecerli_i(res_gecerli_i), .res_hazir_o(res_hazir_o),
    .mem_adres_o(mem_adres_o), .mem_veri_o(mem_veri_o), .mem_gecerli_o(mem_gecerli_o),
    .mem_hazir_i(mem_hazir_i), .yazici_bitti_o(yazici_bitti_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int adres; int veri; } wr_t;
  typedef struct { int row; int col; int veri; int adres; int pix; int wr; } vec_t;

  wr_t exp_q[$];
  vec_t tv[8];
  int mcount = 0, checks = 0, failures = 0, acc_n = 0, wr_n = 0;
  int last_adres = 0, last_veri = 0;
  bit fresh = 1'b0;

  function automatic int model_pix(int v);
`ifdef SONUC_DOYUM_EN
    return v < 0 ? 0 : (v > MAXV ? MAXV : v);
`else
    return v & MAXV;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(int row, int col, int veri, bit gec);
    res_row_i = HB'(row);
    res_col_i = WB'(col);
    res_veri_i = PB'(veri);
    res_gecerli_i = gec;
  endtask

  // one clock: compare against the model before the edge, then apply this edge's handshakes to it
  task automatic cyc();
    int hz, sv;
    wr_t e;
    @(negedge clk_i);
    hz = (!fresh && mcount < N && exp_q.size() < D) ? 1 : 0;
    chk("res_hazir", res_hazir_o, hz);
    chk("mem_gecerli", mem_gecerli_o, exp_q.size() != 0 ? 1 : 0);
    chk("yazici_bitti", yazici_bitti_o, (mcount == N && exp_q.size() == 0) ? 1 : 0);
    chk("kabul_sayac", int'(dut.kabul_sayac), mcount);
    if (exp_q.size() != 0) begin
      chk("mem_adres", mem_adres_o, exp_q[0].adres);
      chk("mem_veri", mem_veri_o, exp_q[0].veri);
    end
    if (mem_gecerli_o && mem_hazir_i) begin
      wr_n++;
      last_adres = mem_adres_o;
      last_veri = mem_veri_o;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (res_gecerli_i && hz == 1) begin
      acc_n++;
      if (int'(res_row_i) < H && int'(res_col_i) < W) begin
        sv = $signed(res_veri_i);
        e.adres = int'(res_row_i) * W + int'(res_col_i);
        e.veri = model_pix(sv);
        exp_q.push_back(e);
        mcount++;
      end
    end
    fresh = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    res_gecerli_i = 1'b0;
    exp_q.delete();
    mcount = 0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    fresh = 1'b1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_hazir"}, res_hazir_o, 0);
    chk({tag, "_gecerli"}, mem_gecerli_o, 0);
    chk({tag, "_adres"}, mem_adres_o, 0);
    chk({tag, "_veri"}, mem_veri_o, 0);
    chk({tag, "_bitti"}, yazici_bitti_o, 0);
  endtask

  task automatic accept_one(int row, int col, int veri, int budget);
    int a0, n;
    a0 = acc_n;
    n = 0;
    drive(row, col, veri, 1'b1);
    while (acc_n == a0 && n < budget) begin
      cyc();
      n++;
    end
    chk("accept_wait", acc_n - a0, 1);
    res_gecerli_i = 1'b0;
  endtask

  initial begin
    int a0, w0, n;
    tv[0] = '{2, 3, 17, 2*W+3, 17, 1};
    tv[1] = '{0, 0, 0, 0, 0, 1};
    tv[2] = '{H-1, W-1, 255, N-1, 255, 1};
`ifdef SONUC_DOYUM_EN
    tv[3] = '{1, 5, -5, W+5, 0, 1};
    tv[4] = '{1, 6, 300, W+6, 255, 1};
`else
    tv[3] = '{1, 5, -5, W+5, 251, 1};
    tv[4] = '{1, 6, 300, W+6, 44, 1};
`endif
    tv[5] = '{H, 0, 9, 0, 0, 0};
    tv[6] = '{0, W, 9, 0, 0, 0};
    tv[7] = '{(1<<HB)-1, (1<<WB)-1, 9, 0, 0, 0};

    #3 chk_zero("in_reset");
    do_reset();
    mem_hazir_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      accept_one(tv[i].row, tv[i].col, tv[i].veri, 10);
      w0 = wr_n;
      repeat (4) cyc();
      chk("tv_writes", wr_n - w0, tv[i].wr);
      if (tv[i].wr == 1) begin
        chk("tv_adres", last_adres, tv[i].adres);
        chk("tv_veri", last_veri, tv[i].pix);
      end
    end

    // backpressure: four fill the queue, the fifth waits until memory drains
    do_reset();
    mem_hazir_i = 1'b0;
    a0 = acc_n;
    w0 = wr_n;
    for (int i = 0; i < D; i++) accept_one(1, i, 10 + i, 10);
    drive(3, 3, 99, 1'b1);
    repeat (4) cyc();
    chk("bp_blocked", acc_n - a0, D);
    chk("bp_no_write", wr_n - w0, 0);
    mem_hazir_i = 1'b1;
    n = 0;
    while (acc_n - a0 < D + 1 && n < 20) begin
      cyc();
      n++;
    end
    chk("bp_fifth_accept", acc_n - a0, D + 1);
    res_gecerli_i = 1'b0;
    repeat (8) cyc();
    chk("bp_all_written", wr_n - w0, D + 1);
    chk("bp_last_adres", last_adres, 3*W+3);

    // full frame under random memory backpressure
    do_reset();
    n = 0;
    while (!(mcount == N && exp_q.size() == 0) && n < 3000) begin
      mem_hazir_i = 1'($urandom_range(0, 1));
      drive($urandom_range(0, H-1), $urandom_range(0, W-1), $urandom_range(0, (1<<PB)-1),
            1'($urandom_range(0, 3) != 0));
      cyc();
      n++;
    end
    chk("frame_complete", (mcount == N && exp_q.size() == 0) ? 1 : 0, 1);
    chk("frame_bitti", yazici_bitti_o, 1);
    a0 = acc_n;
    w0 = wr_n;
    mem_hazir_i = 1'b1;
    drive(0, 0, 5, 1'b1);
    repeat (8) cyc();
    chk("post_done_accepts", acc_n - a0, 0);
    chk("post_done_writes", wr_n - w0, 0);

    // reset with three entries pending discards them
    do_reset();
    mem_hazir_i = 1'b0;
    for (int i = 0; i < 3; i++) accept_one(2, i, 40 + i, 10);
    #2 rstn_i = 1'b0;
    #1 chk_zero("abort");
    exp_q.delete();
    mcount = 0;
    res_gecerli_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    fresh = 1'b1;
    mem_hazir_i = 1'b1;
    w0 = wr_n;
    repeat (6) cyc();
    chk("abort_no_write", wr_n - w0, 0);
    chk("abort_hazir", res_hazir_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
